// File: rtl/rgb565_beat_packer.sv
// Packs pairs of 64-bit RGB565 beats into 128-bit AXI-Stream beats and regenerates
// frame boundaries from a pixel count, pulsing frame_err on length mismatches.
//
// state | meaning
// LO    | nothing held, next beat becomes the lower half
// HI    | lower half held in lo_q, next beat completes the output
// OUT   | output beat valid, waiting for m_tready
module rgb565_beat_packer #(
  parameter int FRAME_PIXELS = 1024,
  parameter int CNT_W        = 16
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         s_tvalid,
  output logic         s_tready,
  input  logic         s_tlast,
  input  logic [63:0]  rgb565_in,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic         m_tlast,
  output logic [127:0] m_tdata,
  output logic [15:0]  m_tkeep,
  output logic         frame_err
);

  typedef enum logic [1:0] {ST_LO, ST_HI, ST_OUT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        lo_q, lo_d;
  logic [127:0]       data_q, data_d;
  logic [15:0]        keep_q, keep_d;
  logic               last_q, last_d;
  logic               err_q, err_d;

  logic [CNT_W-1:0]   cnt_next;
  logic               cnt_hit;
  logic               end_evt;
  logic               in_acc;

  assign s_tready = !areset && ((state_q != ST_OUT) || m_tready);
  assign in_acc   = s_tvalid && s_tready;
  assign cnt_next = cnt_q + CNT_W'(4);
  assign cnt_hit  = (cnt_next == CNT_W'(FRAME_PIXELS));
  assign end_evt  = s_tlast || cnt_hit;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_LO;
      cnt_q   <= '0;
      lo_q    <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LO:   if (in_acc) state_d = end_evt ? ST_OUT : ST_HI;
      ST_HI:   if (in_acc) state_d = ST_OUT;
      ST_OUT: begin
        // Accepting alongside the output handshake treats the new beat as a fresh lower half
        if (m_tready) begin
          if (in_acc) state_d = end_evt ? ST_OUT : ST_HI;
          else        state_d = ST_LO;
        end
      end
      default: state_d = ST_LO;
    endcase
  end

  always_comb begin
    lo_d   = lo_q;
    data_d = data_q;
    keep_d = keep_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    err_d  = 1'b0;
    if (in_acc) begin
      cnt_d = end_evt ? '0 : cnt_next;
      err_d = (s_tlast != cnt_hit);
      if (state_q == ST_HI) begin
        data_d = {rgb565_in, lo_q};
        keep_d = 16'hFFFF;
        last_d = end_evt;
      end else begin
        lo_d = rgb565_in;
        if (end_evt) begin
          data_d = {64'h0, rgb565_in};
          keep_d = 16'h00FF;
          last_d = 1'b1;
        end
      end
    end
  end

  assign m_tvalid  = (state_q == ST_OUT);
  assign m_tdata   = data_q;
  assign m_tkeep   = keep_q;
  assign m_tlast   = last_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_rgb565_beat_packer.sv
// Scoreboard bench for rgb565_beat_packer with a 16-pixel frame: directed framing
// cases followed by randomized output backpressure.
module tb_rgb565_beat_packer;

  localparam int FP = 16;

  logic         aclk = 1'b0;
  logic         areset;
  logic         s_tvalid;
  logic         s_tready;
  logic         s_tlast;
  logic [63:0]  rgb565_in;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic [127:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic         frame_err;

  rgb565_beat_packer #(.FRAME_PIXELS(FP), .CNT_W(16)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tlast   (s_tlast),
    .rgb565_in (rgb565_in),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .m_tdata   (m_tdata),
    .m_tkeep   (m_tkeep),
    .frame_err (frame_err)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       e;
  beat_t       held;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          m_cnt    = 0;
  bit          m_pend   = 0;
  logic [63:0] m_lo     = '0;
  bit          err_exp  = 0;
  bit          stall_prev = 0;
  bit          rand_en  = 0;
  bit          hit;
  bit          endv;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Monitor and reference model, sampled mid-cycle
  always @(negedge aclk) begin
    if (areset) begin
      m_cnt = 0; m_pend = 0; err_exp = 0; stall_prev = 0;
    end else begin
      chk("frame_err", 128'(frame_err), 128'(err_exp));
      chk("s_tready", 128'(s_tready), 128'(!m_tvalid || m_tready));
      if (stall_prev) begin
        chk("stall_valid", 128'(m_tvalid), 128'(1'b1));
        chk("stall_data", m_tdata, held.d);
        chk("stall_keep", 128'(m_tkeep), 128'(held.k));
        chk("stall_last", 128'(m_tlast), 128'(held.l));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 128'(m_tvalid), 128'(1'b0));
        end else begin
          e = exp_q.pop_front();
          chk("out_data", m_tdata, e.d);
          chk("out_keep", 128'(m_tkeep), 128'(e.k));
          chk("out_last", 128'(m_tlast), 128'(e.l));
        end
      end
      stall_prev = m_tvalid && !m_tready;
      held = '{d: m_tdata, k: m_tkeep, l: m_tlast};
      err_exp = 0;
      if (s_tvalid && s_tready) begin
        m_cnt   = m_cnt + 4;
        hit     = (m_cnt == FP);
        endv    = s_tlast || hit;
        err_exp = (s_tlast != hit);
        if (m_pend) begin
          exp_q.push_back('{d: {rgb565_in, m_lo}, k: 16'hFFFF, l: endv});
          m_pend = 0;
        end else if (endv) begin
          exp_q.push_back('{d: {64'h0, rgb565_in}, k: 16'h00FF, l: 1'b1});
        end else begin
          m_lo   = rgb565_in;
          m_pend = 1;
        end
        if (endv) m_cnt = 0;
      end
    end
  end

  always @(posedge aclk) begin
    #1;
    if (rand_en) m_tready = ($urandom_range(0, 1) == 1);
  end

  task automatic send(input logic [63:0] d, input logic l);
    bit acc = 0;
    s_tvalid  = 1'b1;
    rgb565_in = d;
    s_tlast   = l;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge aclk);
      acc = s_tready;
      @(posedge aclk);
      #1;
    end
    if (!acc) chk("send_timeout", 128'(acc), 128'(1'b1));
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    areset    = 1'b1;
    s_tvalid  = 1'b1;
    s_tlast   = 1'b0;
    rgb565_in = '1;
    m_tready  = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      chk("rst_s_tready", 128'(s_tready), 128'(1'b0));
      chk("rst_m_tvalid", 128'(m_tvalid), 128'(1'b0));
      chk("rst_frame_err", 128'(frame_err), 128'(1'b0));
      chk("rst_m_tdata", m_tdata, 128'(0));
      chk("rst_m_tkeep", 128'(m_tkeep), 128'(0));
      chk("rst_m_tlast", 128'(m_tlast), 128'(1'b0));
    end
    @(posedge aclk);
    #1;
    areset   = 1'b0;
    s_tvalid = 1'b0;

    // Pack pair, then close the frame
    send(64'h1111_2222_3333_4444, 1'b0);
    send(64'h5555_6666_7777_8888, 1'b0);
    s_tvalid = 1'b0;
    @(negedge aclk);
    chk("latency_valid", 128'(m_tvalid), 128'(1'b1));
    @(posedge aclk);
    #1;
    send(64'hAAAA_0001_AAAA_0002, 1'b0);
    send(64'hAAAA_0003_AAAA_0004, 1'b1);
    idle();

    // Full frame
    for (int i = 0; i < 4; i++) send({48'hF00D_0000_0000, 16'(i)}, i == 3);
    idle();

    // Short odd frame
    for (int i = 0; i < 3; i++) send({48'h5407_0000_0000, 16'(i)}, i == 2);
    idle();

    // Long frame, then finish the frame started by its 5th beat
    for (int i = 0; i < 5; i++) send({48'h1096_0000_0000, 16'(i)}, 1'b0);
    for (int i = 0; i < 3; i++) send({48'h2096_0000_0000, 16'(i)}, i == 2);
    idle();

    // Backpressure
    rand_en = 1;
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      send({$urandom, $urandom}, (i % 4) == 3);
    end
    idle();
    rand_en  = 0;
    @(posedge aclk);
    #2;
    m_tready = 1'b1;

    for (int i = 0; i < 200 && (exp_q.size() != 0 || m_tvalid); i++) @(negedge aclk);
    chk("drain_queue", 128'(exp_q.size()), 128'(0));
    chk("drain_valid", 128'(m_tvalid), 128'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
